// File: rtl/alu_exec.sv
// Execute stage: latches operands at start and computes an 8-bit result that it writes back to the register bank.
// Latency: 2 cycles from start to writeback for single-cycle ops, 9 cycles for MUL (an 8-step shift-add).
// Backpressure: start is dropped while busy, except in WB where a new start is accepted; cen=0 freezes everything and masks we_o/done.
module alu_exec #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [AW-1:0] rd,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rd_o,
    output logic [W-1:0]  dat_o,
    output logic          we_o,
    output logic          zf,
    output logic          cf
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_WB} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

    state_t          state;
    logic [2:0]      op_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [2*W-1:0]  acc;
    logic [2:0]      cnt;

    logic [W:0]      sum;
    logic [W:0]      diff;
    logic [2*W-1:0]  shl_full;
    logic [2*W-1:0]  acc_next;
    logic [W-1:0]    res;
    logic            res_cf;

    assign sum      = {1'b0, a_q} + {1'b0, b_q};
    assign diff     = {1'b0, a_q} - {1'b0, b_q};
    assign shl_full = {{W{1'b0}}, a_q} << b_q[2:0];
    assign acc_next = acc + (b_q[cnt] ? ({{W{1'b0}}, a_q} << cnt) : {(2*W){1'b0}});

    always_comb begin
        res    = '0;
        res_cf = 1'b0;
        case (op_q)
            OP_ADD: begin res = sum[W-1:0];  res_cf = sum[W];  end
            OP_SUB: begin res = diff[W-1:0]; res_cf = diff[W]; end
            OP_AND: res = a_q & b_q;
            OP_OR:  res = a_q | b_q;
            OP_XOR: res = a_q ^ b_q;
            OP_SHL: begin res = shl_full[W-1:0]; res_cf = |shl_full[2*W-1:W]; end
            default: res = b_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            rd_o  <= '0;
            acc   <= '0;
            cnt   <= '0;
            dat_o <= '0;
            zf    <= 1'b0;
            cf    <= 1'b0;
        end else if (cen) begin
            case (state)
                // WB ends in the same edge that may accept the next request,
                // so back-to-back single-cycle ops write every other cycle.
                S_IDLE, S_WB: begin
                    if (start) begin
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                        rd_o  <= rd;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= (op == OP_MUL) ? S_MUL : S_EXEC;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    dat_o <= res;
                    cf    <= res_cf;
                    zf    <= (res == '0);
                    state <= S_WB;
                end
                S_MUL: begin
                    acc <= acc_next;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        dat_o <= acc_next[W-1:0];
                        cf    <= |acc_next[2*W-1:W];
                        zf    <= (acc_next[W-1:0] == '0);
                        state <= S_WB;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign we_o = cen && (state == S_WB);
    assign done = we_o;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec with a behavioural register bank on its write port.
module tb_alu_exec;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cen = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op = '0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] rd = '0;
    logic       busy, done, we_o, zf, cf;
    logic [2:0] rd_o;
    logic [7:0] dat_o;

    int n_tests = 0;
    int n_fail  = 0;

    alu_exec #(.W(8), .AW(3)) dut (
        .clk(clk), .rst(rst), .cen(cen), .start(start), .op(op),
        .a(a), .b(b), .rd(rd), .busy(busy), .done(done), .rd_o(rd_o),
        .dat_o(dat_o), .we_o(we_o), .zf(zf), .cf(cf)
    );

    always #5 clk = ~clk;

    logic [7:0] bank [8];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) bank[i] <= 8'hAA;
        end else if (we_o) begin
            bank[rd_o] <= dat_o;
        end
    end

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] rd;
        logic [7:0] dat;
        logic       zf;
        logic       cf;
        int         lat;
    } vec_t;

    vec_t vecs[15];

    int         r_we_idx, r_we_cnt, r_busy;
    logic [7:0] r_dat;
    logic       r_zf, r_cf, r_done;
    logic [2:0] r_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Issues one request, scrambles the inputs after acceptance, then watches 20 cycles.
    task automatic run_op(input logic [2:0] o, input logic [7:0] ia, input logic [7:0] ib,
                          input logic [2:0] ird, input int stall_at, input int stall_len,
                          input int dup_at);
        r_we_idx = -1; r_we_cnt = 0; r_busy = 0;
        r_dat = '0; r_zf = 1'b0; r_cf = 1'b0; r_done = 1'b0; r_rd = '0;
        @(negedge clk);
        op = o; a = ia; b = ib; rd = ird; start = 1'b1; cen = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~ia; b = ~ib; op = o ^ 3'b101; rd = ird + 3'd1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) r_busy++;
            if (we_o) begin
                if (r_we_cnt == 0) begin
                    r_we_idx = i;
                    r_dat = dat_o; r_zf = zf; r_cf = cf; r_rd = rd_o; r_done = done;
                end
                r_we_cnt++;
            end
            start = (i == dup_at);
            cen = !(stall_at >= 0 && i >= stall_at && i < stall_at + stall_len);
        end
        start = 1'b0;
        cen = 1'b1;
    endtask

    task automatic check_run(input string tag, input logic [2:0] ird, input logic [7:0] edat,
                             input logic ezf, input logic ecf, input int lat);
        chk({tag, "_we_idx"}, r_we_idx, lat);
        chk({tag, "_we_cnt"}, r_we_cnt, 1);
        chk({tag, "_busy_cycles"}, r_busy, lat + 1);
        chk({tag, "_dat"}, r_dat, edat);
        chk({tag, "_zf"}, r_zf, ezf);
        chk({tag, "_cf"}, r_cf, ecf);
        chk({tag, "_rd_o"}, r_rd, ird);
        chk({tag, "_done"}, r_done, 1'b1);
        chk({tag, "_bank"}, bank[ird], edat);
    endtask

    initial begin
        vecs[0]  = '{3'b000, 8'hFF, 8'h01, 3'd3, 8'h00, 1'b1, 1'b1, 1};
        vecs[1]  = '{3'b001, 8'h05, 8'h07, 3'd1, 8'hFE, 1'b0, 1'b1, 1};
        vecs[2]  = '{3'b101, 8'h81, 8'h01, 3'd2, 8'h02, 1'b0, 1'b1, 1};
        vecs[3]  = '{3'b110, 8'h0F, 8'h11, 3'd4, 8'hFF, 1'b0, 1'b0, 8};
        vecs[4]  = '{3'b110, 8'h10, 8'h10, 3'd5, 8'h00, 1'b1, 1'b1, 8};
        vecs[5]  = '{3'b010, 8'hF0, 8'h3C, 3'd6, 8'h30, 1'b0, 1'b0, 1};
        vecs[6]  = '{3'b011, 8'h0F, 8'h30, 3'd7, 8'h3F, 1'b0, 1'b0, 1};
        vecs[7]  = '{3'b100, 8'hAA, 8'hFF, 3'd0, 8'h55, 1'b0, 1'b0, 1};
        vecs[8]  = '{3'b111, 8'h12, 8'h34, 3'd1, 8'h34, 1'b0, 1'b0, 1};
        vecs[9]  = '{3'b000, 8'h12, 8'h34, 3'd2, 8'h46, 1'b0, 1'b0, 1};
        vecs[10] = '{3'b001, 8'h07, 8'h05, 3'd3, 8'h02, 1'b0, 1'b0, 1};
        vecs[11] = '{3'b001, 8'h05, 8'h05, 3'd4, 8'h00, 1'b1, 1'b0, 1};
        vecs[12] = '{3'b101, 8'h01, 8'h07, 3'd5, 8'h80, 1'b0, 1'b0, 1};
        vecs[13] = '{3'b101, 8'hFF, 8'h03, 3'd6, 8'hF8, 1'b0, 1'b1, 1};
        vecs[14] = '{3'b110, 8'hFF, 8'hFF, 3'd7, 8'h01, 1'b0, 1'b1, 8};

        // Reset state
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_we", we_o, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_dat", dat_o, 8'h00);
        chk("rst_rd_o", rd_o, 3'd0);
        chk("rst_zf", zf, 1'b0);
        chk("rst_cf", cf, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 15; k++) begin
            run_op(vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].rd, -1, 0, -1);
            check_run($sformatf("v%0d", k), vecs[k].rd, vecs[k].dat, vecs[k].zf, vecs[k].cf, vecs[k].lat);
        end

        // MUL with a 3-cycle stall in the middle of the iterations
        run_op(3'b110, 8'h0F, 8'h11, 3'd2, 3, 3, -1);
        check_run("mul_stall", 3'd2, 8'hFF, 1'b0, 1'b0, 11);

        // Second start during a busy MUL is dropped
        run_op(3'b110, 8'h10, 8'h10, 3'd3, -1, 0, 3);
        check_run("mul_dup", 3'd3, 8'h00, 1'b1, 1'b1, 8);

        // Back-to-back ADDs: second accepted at the edge that ends the first WB
        @(negedge clk);
        op = 3'b000; a = 8'h01; b = 8'h02; rd = 3'd1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 8'h03; b = 8'h04; rd = 3'd2;
        @(negedge clk);
        chk("b2b_we1", we_o, 1'b1);
        chk("b2b_dat1", dat_o, 8'h03);
        chk("b2b_rd1", rd_o, 3'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("b2b_gap_we", we_o, 1'b0);
        chk("b2b_gap_busy", busy, 1'b1);
        @(negedge clk);
        chk("b2b_we2", we_o, 1'b1);
        chk("b2b_dat2", dat_o, 8'h07);
        chk("b2b_rd2", rd_o, 3'd2);
        @(negedge clk);
        chk("b2b_idle", busy, 1'b0);
        chk("b2b_bank1", bank[1], 8'h03);
        chk("b2b_bank2", bank[2], 8'h07);

        // Asynchronous reset during MUL iteration 4
        @(negedge clk);
        op = 3'b110; a = 8'hFF; b = 8'hFF; rd = 3'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_we", we_o, 1'b0);
        chk("arst_dat", dat_o, 8'h00);
        chk("arst_rd_o", rd_o, 3'd0);
        chk("arst_cf", cf, 1'b0);
        begin
            int we_seen;
            we_seen = 0;
            repeat (2) @(negedge clk);
            rst = 1'b1;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (we_o) we_seen++;
            end
            chk("arst_no_we", we_seen, 0);
            chk("arst_bank5", bank[5], 8'hAA);
        end
        run_op(3'b000, 8'h12, 8'h34, 3'd5, -1, 0, -1);
        check_run("post_rst", 3'd5, 8'h46, 1'b0, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
